// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller handshake: the pipeline-status inputs and the per-stage register controls.
// The pipeline uses master; the hazard controller uses slave.
interface pipeline_hazard_controller_if;
    logic [4:0]  id_rs1_address;
    logic [4:0]  id_rs2_address;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd_address;
    logic        ex_reg_write_enable;
    logic        ex_is_load;
    logic        ex_is_multicycle;
    logic        mem_stdout_write_enable;
    logic        stdout_ready;
    logic        mem_redirect;

    logic        pc_write_enable;
    logic        if_id_write_enable;
    logic        if_id_flush;
    logic        id_ex_write_enable;
    logic        id_ex_flush;
    logic        ex_mem_write_enable;
    logic        ex_mem_flush;
    logic        mem_wb_write_enable;
    logic        mem_wb_flush;
    logic        ex_busy;
    logic [31:0] stall_count;

    modport master (
        output id_rs1_address, id_rs2_address, id_uses_rs1, id_uses_rs2,
               ex_rd_address, ex_reg_write_enable, ex_is_load, ex_is_multicycle,
               mem_stdout_write_enable, stdout_ready, mem_redirect,
        input  pc_write_enable, if_id_write_enable, if_id_flush,
               id_ex_write_enable, id_ex_flush, ex_mem_write_enable, ex_mem_flush,
               mem_wb_write_enable, mem_wb_flush, ex_busy, stall_count
    );

    modport slave (
        input  id_rs1_address, id_rs2_address, id_uses_rs1, id_uses_rs2,
               ex_rd_address, ex_reg_write_enable, ex_is_load, ex_is_multicycle,
               mem_stdout_write_enable, stdout_ready, mem_redirect,
        output pc_write_enable, if_id_write_enable, if_id_flush,
               id_ex_write_enable, id_ex_flush, ex_mem_write_enable, ex_mem_flush,
               mem_wb_write_enable, mem_wb_flush, ex_busy, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: MEM back-pressure, MEM redirects,
// fixed-latency multi-cycle EX ops and load-use hazards, in that priority order.
module pipeline_hazard_controller #(
    parameter int MULTI_LATENCY = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    pipeline_hazard_controller_if.slave   hz
);

    localparam int CNT_W = $clog2(MULTI_LATENCY) + 1;
    localparam bit MC_EN = (MULTI_LATENCY >= 2);
    localparam logic [CNT_W-1:0] CNT_INIT = MC_EN ? CNT_W'(MULTI_LATENCY - 2) : '0;

    typedef enum logic [0:0] {RUN, EX_BUSY} state_t;

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic [31:0]       stall_count_q;

    logic mem_wait;
    logic redirect;
    logic mc_stall;
    logic load_use;

    logic pc_we;
    logic if_id_we, if_id_fl;
    logic id_ex_we, id_ex_fl;
    logic ex_mem_we, ex_mem_fl;
    logic mem_wb_we, mem_wb_fl;

    function automatic logic load_use_hazard(
        input logic       is_load,
        input logic       rd_we,
        input logic [4:0] rd,
        input logic       uses_rs1,
        input logic [4:0] rs1,
        input logic       uses_rs2,
        input logic [4:0] rs2
    );
        // x0 never holds loaded data, so a load targeting it cannot create a dependency
        return is_load && rd_we && (rd != 5'd0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

    assign mem_wait = hz.mem_stdout_write_enable && !hz.stdout_ready;
    assign redirect = hz.mem_redirect;
    assign mc_stall = MC_EN && (((state == RUN) && hz.ex_is_multicycle) ||
                                ((state == EX_BUSY) && (counter != '0)));
    assign load_use = load_use_hazard(hz.ex_is_load, hz.ex_reg_write_enable, hz.ex_rd_address,
                                      hz.id_uses_rs1, hz.id_rs1_address,
                                      hz.id_uses_rs2, hz.id_rs2_address);

    always_comb begin
        pc_we     = 1'b1;
        if_id_we  = 1'b1;
        if_id_fl  = 1'b0;
        id_ex_we  = 1'b1;
        id_ex_fl  = 1'b0;
        ex_mem_we = 1'b1;
        ex_mem_fl = 1'b0;
        mem_wb_we = 1'b1;
        mem_wb_fl = 1'b0;
        if (!reset_n) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
        end else if (mem_wait) begin
            // Whole pipe holds; a bubble enters WB so the waiting store is not retired twice
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
            mem_wb_fl = 1'b1;
        end else if (redirect) begin
            if_id_fl  = 1'b1;
            id_ex_fl  = 1'b1;
            ex_mem_fl = 1'b1;
        end else if (mc_stall) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_fl = 1'b1;
        end else if (load_use) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_fl  = 1'b1;
        end
    end

    // State update at the clock edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= RUN;
            counter       <= '0;
            stall_count_q <= '0;
        end else begin
            if (!pc_we)
                stall_count_q <= stall_count_q + 32'd1;
            if (!mem_wait) begin
                if (redirect) begin
                    state   <= RUN;
                    counter <= '0;
                end else if (MC_EN && (state == RUN) && hz.ex_is_multicycle) begin
                    state   <= EX_BUSY;
                    counter <= CNT_INIT;
                end else if (state == EX_BUSY) begin
                    if (counter != '0)
                        counter <= counter - 1'b1;
                    else
                        state <= RUN;
                end
            end
        end
    end

    assign hz.pc_write_enable     = pc_we;
    assign hz.if_id_write_enable  = if_id_we;
    assign hz.if_id_flush         = if_id_fl;
    assign hz.id_ex_write_enable  = id_ex_we;
    assign hz.id_ex_flush         = id_ex_fl;
    assign hz.ex_mem_write_enable = ex_mem_we;
    assign hz.ex_mem_flush        = ex_mem_fl;
    assign hz.mem_wb_write_enable = mem_wb_we;
    assign hz.mem_wb_flush        = mem_wb_fl;
    assign hz.ex_busy             = (state == EX_BUSY);
    assign hz.stall_count         = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MULTI_LATENCY=4): a per-cycle vector table
// followed by hand-written stdout-wait and reset sequences.
module tb_pipeline_hazard_controller;

    // {pc_we, if_id_we, if_id_fl, id_ex_we, id_ex_fl, ex_mem_we, ex_mem_fl, mem_wb_we, mem_wb_fl}
    localparam logic [8:0] NORM    = 9'b1_10_10_10_10;
    localparam logic [8:0] LU      = 9'b0_00_11_10_10;
    localparam logic [8:0] MC      = 9'b0_00_00_11_10;
    localparam logic [8:0] MEMWAIT = 9'b0_00_00_00_01;
    localparam logic [8:0] REDIR   = 9'b1_11_11_11_10;
    localparam logic [8:0] ZERO    = 9'b0_00_00_00_00;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [4:0]  rd;
        logic        rwe, ld, mc, sout, rdy, redir;
        logic [8:0]  exp_en;
        logic        exp_busy;
        logic [31:0] exp_sc;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    vec_t vecs[21];

    pipeline_hazard_controller_if hz();

    pipeline_hazard_controller #(.MULTI_LATENCY(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic rwe, input logic ld, input logic mc,
                                input logic sout, input logic rdy, input logic redir,
                                input logic [8:0] en, input logic busy, input logic [31:0] sc);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.rwe = rwe; v.ld = ld; v.mc = mc; v.sout = sout; v.rdy = rdy; v.redir = redir;
        v.exp_en = en; v.exp_busy = busy; v.exp_sc = sc;
        return v;
    endfunction

    function automatic vec_t idle(input logic [8:0] en, input logic busy, input logic [31:0] sc);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, en, busy, sc);
    endfunction

    function automatic vec_t mcv(input logic sout, input logic rdy, input logic redir,
                                 input logic [8:0] en, input logic busy, input logic [31:0] sc);
        return mk(0, 0, 0, 0, 0, 0, 0, 1, sout, rdy, redir, en, busy, sc);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hz.id_rs1_address          = v.rs1;
        hz.id_rs2_address          = v.rs2;
        hz.id_uses_rs1             = v.u1;
        hz.id_uses_rs2             = v.u2;
        hz.ex_rd_address           = v.rd;
        hz.ex_reg_write_enable     = v.rwe;
        hz.ex_is_load              = v.ld;
        hz.ex_is_multicycle        = v.mc;
        hz.mem_stdout_write_enable = v.sout;
        hz.stdout_ready            = v.rdy;
        hz.mem_redirect            = v.redir;
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then cross the next posedge
    task automatic step(input string tag, input vec_t v);
        logic [8:0] en;
        drive(v);
        #2;
        en = {hz.pc_write_enable, hz.if_id_write_enable, hz.if_id_flush,
              hz.id_ex_write_enable, hz.id_ex_flush, hz.ex_mem_write_enable,
              hz.ex_mem_flush, hz.mem_wb_write_enable, hz.mem_wb_flush};
        chk({tag, "_en"}, 32'(en), 32'(v.exp_en));
        chk({tag, "_busy"}, 32'(hz.ex_busy), 32'(v.exp_busy));
        chk({tag, "_stall_count"}, hz.stall_count, v.exp_sc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = idle(NORM, 0, 0);
        vecs[1]  = mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 1, 0, LU, 0, 0);      // load-use on rs1
        vecs[2]  = idle(NORM, 0, 1);                                     // exactly one stall
        vecs[3]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, NORM, 0, 1);    // load to x0
        vecs[4]  = mk(3, 7, 0, 1, 7, 1, 1, 0, 0, 1, 0, LU, 0, 1);      // load-use on rs2
        vecs[5]  = mk(7, 2, 0, 1, 7, 1, 1, 0, 0, 1, 0, NORM, 0, 2);    // rs1 matches but unused
        vecs[6]  = mk(7, 0, 1, 0, 7, 0, 1, 0, 0, 1, 0, NORM, 0, 2);    // load without rd write
        vecs[7]  = mk(7, 0, 1, 0, 7, 1, 0, 0, 0, 1, 0, NORM, 0, 2);    // non-load producer
        vecs[8]  = mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 1, 1, REDIR, 0, 2);   // redirect beats load-use
        vecs[9]  = mcv(0, 1, 0, MC, 0, 2);                               // multi-cycle enters
        vecs[10] = mcv(0, 1, 0, MC, 1, 3);
        vecs[11] = mcv(0, 1, 0, MC, 1, 4);
        vecs[12] = mcv(0, 1, 0, NORM, 1, 5);                             // 4th cycle advances
        vecs[13] = idle(NORM, 0, 5);
        vecs[14] = mcv(0, 1, 0, MC, 0, 5);
        vecs[15] = mcv(0, 1, 1, REDIR, 1, 6);                            // redirect aborts EX_BUSY
        vecs[16] = idle(NORM, 0, 6);
        vecs[17] = mk(5, 0, 1, 0, 5, 1, 1, 0, 1, 0, 0, MEMWAIT, 0, 6); // stdout wait beats load-use
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, NORM, 0, 7);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, MEMWAIT, 0, 7); // stdout wait beats redirect
        vecs[20] = idle(NORM, 0, 8);

        reset_n = 1'b0;
        drive(idle(NORM, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        step("reset", idle(ZERO, 0, 0));
        reset_n = 1'b1;

        for (int i = 0; i < 21; i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // stdout back-pressure inside EX_BUSY: five frozen cycles, then the op resumes
        step("sw_enter", mcv(0, 1, 0, MC, 0, 8));
        for (int k = 0; k < 5; k++)
            step($sformatf("sw_wait%0d", k), mcv(1, 0, 0, MEMWAIT, 1, 32'(9 + k)));
        step("sw_resume0", mcv(1, 1, 0, MC, 1, 14));
        step("sw_resume1", mcv(0, 1, 0, MC, 1, 15));
        step("sw_done", mcv(0, 1, 0, NORM, 1, 16));
        step("sw_idle", idle(NORM, 0, 16));

        // reset while EX_BUSY with counter=1
        step("rb_enter", mcv(0, 1, 0, MC, 0, 16));
        step("rb_cnt2", mcv(0, 1, 0, MC, 1, 17));
        reset_n = 1'b0;
        step("rb_reset", mcv(0, 1, 0, ZERO, 1, 18));
        reset_n = 1'b1;
        step("rb_after", idle(NORM, 0, 0));

        // reset during a stdout wait
        step("rw_wait", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MEMWAIT, 0, 0));
        reset_n = 1'b0;
        step("rw_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ZERO, 0, 1));
        reset_n = 1'b1;
        step("rw_after", idle(NORM, 0, 0));
        step("rw_load_use", mk(9, 0, 1, 0, 9, 1, 1, 0, 0, 1, 0, LU, 0, 0));
        step("rw_final", idle(NORM, 0, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
